stage_if: RTL and testbench

//  Instruction-fetch stage; feeds pipe_if_id through pc_o/inst_o.

---
 rtl/stage_if_pkg.sv | 19 +
 rtl/stage_if_if.sv | 12 +
 rtl/stage_if_icache_dm.sv | 43 ++++
 rtl/stage_if.sv | 120 ++++++++++++
 tb/tb_stage_if.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its icache.
package stage_if_pkg;

   localparam int ICACHE_IDX_DEF = 7;
   localparam int ADDR_WIDTH_DEF = 17;

   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   typedef enum logic {
      IF_IDLE = 1'b0,
      IF_WAIT = 1'b1
   } if_state_e;

   // Redirect targets may carry junk in the byte-offset bits.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/stage_if_if.sv
// Fetch request/response channel between the IF stage and the memory controller.
interface stage_if_if;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_data;

   modport master (output mem_req, output mem_addr, input mem_ready, input mem_data);
   modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_data);

endinterface

// File: rtl/stage_if_icache_dm.sv
// Direct-mapped instruction cache, one word per line, combinational read.
module icache_dm #(
   parameter int IDX_W = 7,
   parameter int TAG_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             hit,
   output logic [31:0]      rd_data,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   // Only the valid bits need clearing; stale tag/data behind a clear bit is never used.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
      end else if (we) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (we) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
   assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC register, miss FSM, fill bypass and output mux.
module stage_if
   import stage_if_pkg::*;
#(
   parameter int ICACHE_IDX = ICACHE_IDX_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_flag,
   input  logic [31:0] br_target,
   stage_if_if.master  mem,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        stall_req
);

   localparam int TAG_W = ADDR_WIDTH - ICACHE_IDX - 2;

   if_state_e   state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] fetch_addr;
   logic        mem_req_q, mem_req_next;
   logic [31:0] mem_addr_q;
   logic        start_fetch, fill, deliver, bypass;
   logic        hit;
   logic [31:0] cache_data;

   icache_dm #(.IDX_W(ICACHE_IDX), .TAG_W(TAG_W)) u_icache (
      .clock   (clock),
      .reset   (reset),
      .rd_idx  (pc[ICACHE_IDX+1:2]),
      .rd_tag  (pc[ADDR_WIDTH-1:ICACHE_IDX+2]),
      .hit     (hit),
      .rd_data (cache_data),
      .we      (fill),
      .wr_idx  (fetch_addr[ICACHE_IDX+1:2]),
      .wr_tag  (fetch_addr[ADDR_WIDTH-1:ICACHE_IDX+2]),
      .wr_data (mem.mem_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IF_IDLE;
         pc         <= 32'h0;
         fetch_addr <= 32'h0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'h0;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         mem_req_q <= mem_req_next;
         if (start_fetch) begin
            fetch_addr <= pc;
            mem_addr_q <= pc;
         end
      end
   end

   // A redirect suppresses delivery and new misses, but never aborts an outstanding fetch.
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      mem_req_next = mem_req_q;
      start_fetch  = 1'b0;
      fill         = 1'b0;
      deliver      = 1'b0;
      bypass       = 1'b0;
      case (state)
         IF_IDLE: begin
            if (!br_flag) begin
               if (hit) begin
                  deliver = 1'b1;
               end else begin
                  start_fetch  = 1'b1;
                  mem_req_next = 1'b1;
                  state_next   = IF_WAIT;
               end
            end
         end
         IF_WAIT: begin
            if (mem.mem_ready) begin
               fill         = 1'b1;
               mem_req_next = 1'b0;
               state_next   = IF_IDLE;
               if ((fetch_addr == pc) && !br_flag) begin
                  deliver = 1'b1;
                  bypass  = 1'b1;
               end
            end
         end
         default: begin
            state_next = IF_IDLE;
         end
      endcase
      if (br_flag) begin
         pc_next = word_align(br_target);
      end else if (deliver && !stall) begin
         pc_next = pc + 32'd4;
      end
   end

   always_comb begin
      stall_req = 1'b1;
      inst_o    = INST_NOP;
      pc_o      = 32'h0;
      if (!reset) begin
         pc_o      = pc;
         stall_req = !deliver;
         if (deliver) begin
            inst_o = bypass ? mem.mem_data : cache_data;
         end
      end
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed self-checking bench for stage_if with a fixed-latency memory responder.
module tb_stage_if;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        br_flag = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        stall_req;

   int total = 0;
   int bad = 0;
   int memLat = 3;
   int memCnt = 0;

   stage_if_if memBus ();

   stage_if dut (
      .clock     (clock),
      .reset     (reset),
      .stall     (stall),
      .br_flag   (br_flag),
      .br_target (br_target),
      .mem       (memBus.master),
      .pc_o      (pc_o),
      .inst_o    (inst_o),
      .stall_req (stall_req)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ 32'h1357_2468;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Memory answers after memLat cycles of an asserted request, with a single-cycle ready.
   task automatic memStep();
      if (memBus.mem_ready) begin
         memBus.mem_ready = 1'b0;
         memCnt = 0;
      end else if (memBus.mem_req) begin
         memCnt++;
         if (memCnt > memLat) begin
            memBus.mem_ready = 1'b1;
            memBus.mem_data  = memWord(memBus.mem_addr);
         end
      end else begin
         memCnt = 0;
      end
   endtask

   task automatic applyStimulus();
      @(posedge clock);
      #1;
      memStep();
      #1;
   endtask

   // Starts on the miss cycle; expects 4 stalled cycles then the bypassed word.
   task automatic fetchMiss(input logic [31:0] addr, input string tag);
      for (int i = 0; i < 4; i++) begin
         checkOutput({tag, " stall"}, 32'(stall_req), 32'd1);
         if (i > 0) begin
            checkOutput({tag, " mem_addr"}, memBus.mem_addr, addr);
         end
         applyStimulus();
      end
      checkOutput({tag, " inst"}, inst_o, memWord(addr));
      checkOutput({tag, " pc_o"}, pc_o, addr);
      checkOutput({tag, " deliver"}, 32'(stall_req), 32'd0);
      applyStimulus();
   endtask

   task automatic redirect(input logic [31:0] target);
      br_flag   = 1'b1;
      br_target = target;
      #1;
      checkOutput("redir stall", 32'(stall_req), 32'd1);
      checkOutput("redir inst", inst_o, 32'h0);
      applyStimulus();
      br_flag = 1'b0;
      #1;
   endtask

   initial begin
      memBus.mem_ready = 1'b0;
      memBus.mem_data  = 32'h0;
      applyStimulus();
      applyStimulus();
      checkOutput("rst stall", 32'(stall_req), 32'd1);
      checkOutput("rst inst", inst_o, 32'h0);
      checkOutput("rst pc", pc_o, 32'h0);
      checkOutput("rst mem_req", 32'(memBus.mem_req), 32'd0);
      checkOutput("rst mem_addr", memBus.mem_addr, 32'h0);
      reset = 1'b0;
      #1;

      fetchMiss(32'h0, "t1 pc0");
      fetchMiss(32'h4, "t2 pc4");
      fetchMiss(32'h8, "t2 pc8");
      fetchMiss(32'hC, "t2 pc12");
      redirect(32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t2 hit stall", 32'(stall_req), 32'd0);
         checkOutput("t2 hit mem_req", 32'(memBus.mem_req), 32'd0);
         checkOutput("t2 hit pc", pc_o, 32'(i * 4));
         checkOutput("t2 hit inst", inst_o, memWord(32'(i * 4)));
         if (i == 1) begin
            memBus.mem_ready = 1'b1;
            memBus.mem_data  = 32'hDEAD_BEEF;
            #1;
            checkOutput("idle ready ignored", inst_o, memWord(32'h4));
         end
         applyStimulus();
      end

      redirect(32'h0000_000B);
      stall = 1'b1;
      #1;
      checkOutput("t3 pc", pc_o, 32'h8);
      checkOutput("t3 inst", inst_o, memWord(32'h8));
      checkOutput("t3 stall_req", 32'(stall_req), 32'd0);
      applyStimulus();
      checkOutput("t3 hold pc", pc_o, 32'h8);
      checkOutput("t3 hold inst", inst_o, memWord(32'h8));
      stall = 1'b0;
      #1;
      checkOutput("t3 release pc", pc_o, 32'h8);
      applyStimulus();
      checkOutput("t3 next pc", pc_o, 32'hC);
      checkOutput("t3 next inst", inst_o, memWord(32'hC));
      checkOutput("t3 next stall_req", 32'(stall_req), 32'd0);
      applyStimulus();

      redirect(32'h20);
      checkOutput("t4 miss stall", 32'(stall_req), 32'd1);
      applyStimulus();
      checkOutput("t4 mem_req", 32'(memBus.mem_req), 32'd1);
      checkOutput("t4 mem_addr", memBus.mem_addr, 32'h20);
      redirect(32'h100);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t4 no deliver stall", 32'(stall_req), 32'd1);
         checkOutput("t4 no deliver inst", inst_o, 32'h0);
         checkOutput("t4 held addr", memBus.mem_addr, 32'h20);
         applyStimulus();
      end
      fetchMiss(32'h100, "t4 pc100");
      redirect(32'h20);
      checkOutput("t4 filled stall", 32'(stall_req), 32'd0);
      checkOutput("t4 filled inst", inst_o, memWord(32'h20));
      checkOutput("t4 filled pc", pc_o, 32'h20);
      checkOutput("t4 filled mem_req", 32'(memBus.mem_req), 32'd0);
      applyStimulus();

      redirect(32'h200);
      fetchMiss(32'h200, "t5 a");
      redirect(32'h0);
      fetchMiss(32'h0, "t5 b");
      redirect(32'h200);
      fetchMiss(32'h200, "t5 c");

      redirect(32'hFFFF_FFFC);
      fetchMiss(32'hFFFF_FFFC, "wrap top");
      checkOutput("wrap pc", pc_o, 32'h0);
      checkOutput("wrap miss", 32'(stall_req), 32'd1);

      applyStimulus();
      checkOutput("t6 mem_req", 32'(memBus.mem_req), 32'd1);
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      checkOutput("t6 rst mem_req", 32'(memBus.mem_req), 32'd0);
      checkOutput("t6 rst pc", pc_o, 32'h0);
      checkOutput("t6 rst stall", 32'(stall_req), 32'd1);
      reset = 1'b0;
      #1;
      fetchMiss(32'h0, "t6 refetch");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
